// File: rtl/hamming_tx_encoder.sv
// Transmit-side channel encoder: buffers 4-bit nibbles in a FIFO, encodes each into an
// 8-bit systematic parity codeword and serializes it LSB pair first as four 2-bit symbols.
module hamming_tx_encoder #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mod_en,
    output logic [1:0] out,
    output logic       out_valid,
    output logic       frame_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Codeword {d3,d2,d1,d0,c3,c2,c1,c0}; c3 is folded into c2 and c0.
    function automatic logic [7:0] encode_nibble(input logic [3:0] d);
        logic c3;
        logic c2;
        logic c1;
        logic c0;
        c3 = d[3] ^ d[2] ^ d[1];
        c2 = d[2] ^ d[0] ^ c3;
        c1 = d[2] ^ d[1] ^ d[0];
        c0 = d[1] ^ d[0] ^ c3;
        return {d, c3, c2, c1, c0};
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]  mem_q [DEPTH];
    logic        in_ready_q, in_ready_d;
    logic [1:0]  out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        frame_done_q, frame_done_d;

    logic        push_s;
    logic        pop_s;
    logic        empty_s;
    logic [3:0]  head_s;

    assign push_s  = in_valid & in_ready_q;
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

    assign in_ready   = in_ready_q;
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

    // Next-state, serializer and FIFO pointer logic.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        pop_s        = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    sh_d    = encode_nibble(head_s);
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (mod_en) begin
                    if (cnt_q != 2'd3) begin
                        sh_d  = {2'b00, sh_q[7:2]};
                        cnt_d = cnt_q + 2'd1;
                    end else begin
                        frame_done_d = 1'b1;
                        cnt_d        = 2'd0;
                        // Back-to-back reload keeps the symbol stream gap-free.
                        if (!empty_s) begin
                            pop_s   = 1'b1;
                            sh_d    = encode_nibble(head_s);
                            state_d = SEND;
                        end else begin
                            sh_d    = 8'h00;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                sh_d    = 8'h00;
                cnt_d   = 2'd0;
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == SEND);
        if (state_d == SEND) begin
            out_d = sh_d[1:0];
        end else begin
            out_d = 2'b00;
        end

        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_s};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_s};
        in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    // State, serializer, pointer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sh_q         <= 8'h00;
            cnt_q        <= 2'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            in_ready_q   <= 1'b1;
            out_q        <= 2'b00;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            in_ready_q   <= in_ready_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Nibble storage; cleared on reset so flushed entries never resurface.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// Directed testbench for hamming_tx_encoder: symbol order, back-to-back frames,
// FIFO full/backpressure, strobe holding, simultaneous push/pop and mid-frame reset.
module tb_hamming_tx_encoder;

    logic       clk;
    logic       reset;
    logic [3:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic       mod_en;
    logic [1:0] out;
    logic       out_valid;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int fd_base;

    logic [7:0] cw;
    logic [7:0] acc;
    logic [1:0] prev;
    logic       held;
    int         nsym;
    int         ncw;
    logic [3:0] rnib [3];
    logic [7:0] exp2 [3];
    logic [7:0] exp3 [5];
    logic [7:0] exp6 [6];

    hamming_tx_encoder #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mod_en     (mod_en),
        .out        (out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-done pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sym(input string tag, input logic [1:0] exp);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, {30'd0, out}, {30'd0, exp});
    endtask

    initial begin
        exp2[0] = 8'h00; exp2[1] = 8'hFF; exp2[2] = 8'h8D;
        exp3[0] = 8'hB4; exp3[1] = 8'h00; exp3[2] = 8'hFF; exp3[3] = 8'h8D; exp3[4] = 8'h65;
        exp6[0] = 8'h17; exp6[1] = 8'h2E; exp6[2] = 8'h4B;
        exp6[3] = 8'h8D; exp6[4] = 8'hB4; exp6[5] = 8'h65;

        reset    = 1'b0;
        data_in  = 4'h0;
        in_valid = 1'b0;
        mod_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {30'd0, out}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        step();

        // Single codeword 0xB4, continuous strobe.
        fd_base  = fd_cnt;
        mod_en   = 1'b1;
        in_valid = 1'b1;
        data_in  = 4'b1011;
        step();
        in_valid = 1'b0;
        check("t1_no_fallthrough", {31'd0, out_valid}, 32'd0);
        step();
        cw = 8'hB4;
        for (int k = 0; k < 4; k++) begin
            check_sym("t1_sym", cw[2*k +: 2]);
            step();
        end
        check("t1_idle_after", {31'd0, out_valid}, 32'd0);
        check("t1_frame_done_pulse", {31'd0, frame_done}, 32'd1);
        step();
        check("t1_frame_done_cnt", fd_cnt - fd_base, 32'd1);

        // Three back-to-back codewords, no gap between frames.
        fd_base  = fd_cnt;
        in_valid = 1'b1;
        data_in  = 4'b0000;
        step();
        check("t2_no_fallthrough", {31'd0, out_valid}, 32'd0);
        data_in = 4'b1111;
        step();
        check_sym("t2_sym0", 2'b00);
        data_in = 4'b1000;
        step();
        in_valid = 1'b0;
        check_sym("t2_sym1", 2'b00);
        for (int i = 2; i < 12; i++) begin
            step();
            cw = exp2[i/4];
            check_sym("t2_sym", cw[2*(i%4) +: 2]);
        end
        step();
        check("t2_idle_after", {31'd0, out_valid}, 32'd0);
        step();
        check("t2_frame_done_cnt", fd_cnt - fd_base, 32'd3);

        // Fill FIFO with strobe off; sixth offer must be refused.
        mod_en   = 1'b0;
        in_valid = 1'b1;
        data_in  = 4'b1011;
        step();
        check("t3_ready_after1", {31'd0, in_ready}, 32'd1);
        data_in = 4'b0000;
        step();
        check_sym("t3_loaded", 2'b00);
        data_in = 4'b1111;
        step();
        data_in = 4'b1000;
        step();
        check("t3_ready_before_full", {31'd0, in_ready}, 32'd1);
        data_in = 4'b0110;
        step();
        check("t3_full", {31'd0, in_ready}, 32'd0);
        data_in = 4'b0101;
        step();
        check("t3_still_full", {31'd0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        mod_en   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cw = exp3[i/4];
            check_sym("t3_drain", cw[2*(i%4) +: 2]);
            step();
            if (i == 3) check("t3_ready_back", {31'd0, in_ready}, 32'd1);
        end
        check("t3_idle_after", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop with two entries queued.
        mod_en   = 1'b0;
        in_valid = 1'b1;
        data_in  = 4'b0001;
        step();
        data_in = 4'b0010;
        step();
        data_in = 4'b0100;
        step();
        in_valid = 1'b0;
        mod_en   = 1'b1;
        check_sym("t6_a0", 2'b11);
        step();
        check_sym("t6_a1", 2'b01);
        step();
        check_sym("t6_a2", 2'b01);
        step();
        check_sym("t6_a3", 2'b00);
        in_valid = 1'b1;
        data_in  = 4'b1000;
        step();
        in_valid = 1'b0;
        mod_en   = 1'b0;
        check("t6_frame_done", {31'd0, frame_done}, 32'd1);
        check("t6_ready_occ2", {31'd0, in_ready}, 32'd1);
        check_sym("t6_reload", 2'b10);
        in_valid = 1'b1;
        data_in  = 4'b1011;
        step();
        check("t6_ready_occ3", {31'd0, in_ready}, 32'd1);
        data_in = 4'b0110;
        step();
        in_valid = 1'b0;
        check("t6_full_occ4", {31'd0, in_ready}, 32'd0);
        mod_en = 1'b1;
        for (int i = 4; i < 24; i++) begin
            cw = exp6[i/4];
            check_sym("t6_drain", cw[2*(i%4) +: 2]);
            step();
        end
        check("t6_idle_after", {31'd0, out_valid}, 32'd0);

        // Random nibbles, strobe every third cycle; check hold, parity and data.
        mod_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnib[i]  = 4'($urandom_range(0, 15));
            in_valid = 1'b1;
            data_in  = rnib[i];
            step();
        end
        in_valid = 1'b0;
        acc  = 8'h00;
        nsym = 0;
        ncw  = 0;
        for (int c = 0; c < 120 && ncw < 3; c++) begin
            mod_en = ((c % 3) == 2);
            held   = 1'b0;
            if (out_valid === 1'b1) begin
                if (mod_en) begin
                    acc = {out, acc[7:2]};
                    nsym++;
                end else begin
                    prev = out;
                    held = 1'b1;
                end
            end
            step();
            if (held) check("t4_hold", {30'd0, out}, {30'd0, prev});
            if (nsym == 4) begin
                nsym = 0;
                check("t4_par", {29'd0, acc[6]^acc[4]^acc[3]^acc[2],
                                        acc[6]^acc[5]^acc[4]^acc[1],
                                        acc[5]^acc[4]^acc[3]^acc[0]}, 32'd0);
                check("t4_data", {28'd0, acc[7:4]}, {28'd0, rnib[ncw]});
                ncw++;
            end
        end
        check("t4_frames_seen", ncw, 32'd3);
        mod_en = 1'b1;
        step();
        step();

        // Reset mid-frame with a second nibble queued; both must be discarded.
        in_valid = 1'b1;
        data_in  = 4'b1011;
        step();
        data_in = 4'b0000;
        step();
        in_valid = 1'b0;
        check_sym("t5_sym0", 2'b00);
        step();
        check_sym("t5_sym1", 2'b01);
        step();
        reset = 1'b0;
        #2;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        check("t5_rst_out", {30'd0, out}, 32'd0);
        #3;
        reset = 1'b1;
        step();
        in_valid = 1'b1;
        data_in  = 4'b1000;
        step();
        in_valid = 1'b0;
        check("t5_no_stale", {31'd0, out_valid}, 32'd0);
        step();
        cw = 8'h8D;
        for (int k = 0; k < 4; k++) begin
            check_sym("t5_sym", cw[2*k +: 2]);
            step();
        end
        check("t5_idle_after", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_tx_encoder.md
# hamming_tx_encoder

Transmit-side channel encoder for the OFDM datapath. It accepts 4-bit data nibbles and buffers them in a small FIFO. Each nibble is encoded into an 8-bit systematic codeword satisfying the receiver's three parity checks. The codeword is serialized as four 2-bit symbols, one per modulator strobe. Sits between the data source and the QPSK mapper; it is the counterpart of the receive-side 2-bit-symbol decoder.

## Interface
- `DEPTH`, default 4: nibble FIFO depth; power of two, at least 2.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `data_in`  in  4: data nibble; d3..d0 = `data_in[3:0]`.
- `in_valid`  in  1: `data_in` is valid this cycle.
- `in_ready`  out  1: FIFO not full; a push occurs on any edge where `in_valid & in_ready`.
- `mod_en`  in  1: modulator symbol strobe; consumes the current symbol when `out_valid` is high.
- `out`  out  2: current symbol.
- `out_valid`  out  1: `out` holds a valid symbol.
- `frame_done`  out  1: one-cycle pulse when the 4th symbol of a codeword is consumed.

## Operation
- Codeword layout is c[7:0]. Data bits are c[7:4] = d3..d0.
- Parity bits:
  - c3 = d3^d2^d1
  - c2 = d2^d0^c3
  - c1 = d2^d1^d0
  - c0 = d1^d0^c3
- Every codeword satisfies all three checks:
  - c6^c4^c3^c2 = 0
  - c6^c5^c4^c1 = 0
  - c5^c4^c3^c0 = 0
- Symbol order is LSB pair first: c[1:0], c[3:2], c[5:4], c[7:6]. The receiver shifts symbols in at the top, so the codeword reassembles in place.
- FIFO:
  - DEPTH entries; read and write pointers are log2(DEPTH)+1 bits, and wrap-around is handled by the extra MSB.
  - full when pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - A push while full is impossible because `in_ready`=0.
- FSM states are IDLE and SEND. The block also holds an 8-bit shift register `sh` and a 2-bit symbol counter `cnt`.
- IDLE:
  - `out_valid`=0 and `mod_en` is ignored.
  - If the FIFO is non-empty: pop the head, load `sh` with its codeword, set `cnt`=0, go to SEND.
- SEND:
  - `out_valid`=1 and `out`=`sh[1:0]`.
  - On `mod_en` with `cnt`<3: `sh` >>= 2 and `cnt`++.
  - On `mod_en` with `cnt`==3: pulse `frame_done`. If the FIFO is non-empty, pop and reload `sh` with `cnt`=0 and stay in SEND (no bubble). Otherwise go to IDLE.
  - Without `mod_en`, `out` holds indefinitely.
- Simultaneous push and pop in the same cycle: both take effect, so the occupancy is unchanged.
- A push into an empty FIFO is not visible to the pop logic until the next cycle (no fall-through).

## Timing
- Reset values: `out`=2'b00, `out_valid`=0, `frame_done`=0, `in_ready`=1, FIFO empty, state IDLE, `cnt`=0, `sh`=0.
- Reset asserted mid-frame aborts immediately: the FIFO is flushed and the partial codeword is discarded.
- Push-to-first-symbol latency with the FSM idle and the FIFO empty:
  - push at edge N;
  - pop and load at edge N+1;
  - `out_valid`=1 after edge N+1.
- Symbol throughput is one symbol per `mod_en` cycle. With continuous `mod_en` and a non-empty FIFO, one codeword goes out every 4 cycles.
- `in_ready` is registered from the FIFO count. It deasserts in the cycle after the push that fills the FIFO and reasserts in the cycle after the next pop.
- `frame_done` asserts in the cycle following the consuming edge and lasts one cycle.

## Test plan
- Reset, then push nibble 4'b1011 and hold `mod_en`=1 → `out` = 00, 01, 11, 10 on consecutive cycles (codeword 0xB4); `frame_done` pulses once; then `out_valid`=0.
- Push 4'b0000, 4'b1111, 4'b1000 back-to-back with `mod_en`=1 → 12 consecutive valid symbols with no gap, encoding codewords 0x00, 0xFF, 0x8D. Symbols are 00,00,00,00 / 11,11,11,11 / 01,11,00,10. `frame_done` pulses 3 times.
- Hold `mod_en`=0 and push 5 nibbles with DEPTH=4 → the 1st is loaded into `sh`, the next 4 fill the FIFO, and `in_ready` drops. A 6th `in_valid` is not accepted; all 5 later emerge in order.
- Toggle `mod_en` every 3rd cycle while streaming random nibbles → each symbol holds between strobes. Reassembling symbols LSB-first gives codewords whose three parity checks are all zero and whose `c[7:4]` equal the pushed data.
- Assert `reset` low after 2 symbols of 4'b1011 → `out_valid`=0 and `in_ready`=1 immediately. After release, push 4'b1000 → a clean 01,11,00,10 sequence.
- Push and pop in the same cycle while the FIFO holds 2 entries → occupancy stays at 2, and no nibble is lost or duplicated.
